// File: rtl/regfile_sb.sv
// Scoreboarded register file: combinational multi-port reads, one writeback port, per-register pending bits.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to matching read ports.
module regfile_sb #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic [NRD*AW-1:0] readReg,
  output logic [NRD*XLEN-1:0] data,
  output logic [NRD-1:0]    busy,
  input  logic              issueEnable,
  input  logic [AW-1:0]     issueReg,
  input  logic              writeEnable,
  input  logic [AW-1:0]     writeReg,
  input  logic [XLEN-1:0]   writeData
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   clrCnt;
  logic [NREG-1:0] pend;
  logic [XLEN-1:0] regs [NREG];

  logic wr_hit;
  logic is_hit;

  assign wr_hit = (state == RUN) && writeEnable && (writeReg != '0);
  assign is_hit = (state == RUN) && issueEnable && (issueReg != '0);
  assign ready  = (state == RUN);

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clrCnt == AW'(NREG - 1)) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  // Control: FSM, clear counter and scoreboard; issue is applied after write so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      clrCnt <= '0;
      pend   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clrCnt <= clrCnt + 1'b1;
      if (wr_hit) pend[writeReg] <= 1'b0;
      if (is_hit) pend[issueReg] <= 1'b1;
    end
  end

  // Storage is zeroed by the CLEAR walk rather than by reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) regs[clrCnt] <= '0;
    else if (wr_hit)    regs[writeReg] <= writeData;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            bz;

    assign ra = readReg[k*AW +: AW];

    always_comb begin
      rd = '0;
      bz = 1'b0;
      if (state == RUN && ra != '0) begin
        if (BYPASS && wr_hit && writeReg == ra) begin
          rd = writeData;
          bz = is_hit && (issueReg == ra);
        end else begin
          rd = regs[ra];
          bz = pend[ra];
        end
      end
    end

    assign data[k*XLEN +: XLEN] = rd;
    assign busy[k]              = bz;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: behavioural model checked every cycle plus literal expectations.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic [9:0]   readReg;
  logic [127:0] data;
  logic [1:0]   busy;
  logic         issueEnable;
  logic [4:0]   issueReg;
  logic         writeEnable;
  logic [4:0]   writeReg;
  logic [63:0]  writeData;

  logic         ready2;
  logic [11:0]  readReg2;
  logic [191:0] data2;
  logic [2:0]   busy2;
  logic         issueEnable2;
  logic [3:0]   issueReg2;
  logic         writeEnable2;
  logic [3:0]   writeReg2;
  logic [63:0]  writeData2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .ready(ready), .readReg(readReg), .data(data), .busy(busy),
    .issueEnable(issueEnable), .issueReg(issueReg), .writeEnable(writeEnable),
    .writeReg(writeReg), .writeData(writeData)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) dut2 (
    .clk(clk), .rst(rst), .ready(ready2), .readReg(readReg2), .data(data2), .busy(busy2),
    .issueEnable(issueEnable2), .issueReg(issueReg2), .writeEnable(writeEnable2),
    .writeReg(writeReg2), .writeData(writeData2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: architectural registers, pending set, and cycles of clearing still to go.
  logic [63:0] mreg [32];
  logic [31:0] mpend = '0;
  int          mclr  = 32;

  initial for (int i = 0; i < 32; i++) mreg[i] = '0;

  always @(posedge clk) begin
    if (rst) begin
      mclr  <= 32;
      mpend <= '0;
      for (int i = 0; i < 32; i++) mreg[i] <= '0;
    end else if (mclr > 0) begin
      mclr <= mclr - 1;
    end else begin
      logic [31:0] np;
      np = mpend;
      if (writeEnable && writeReg != 0) begin
        mreg[writeReg] <= writeData;
        np[writeReg] = 1'b0;
      end
      if (issueEnable && issueReg != 0) np[issueReg] = 1'b1;
      mpend <= np;
    end
  end

  function automatic void exp_rd(input logic [4:0] a, output logic [63:0] d, output logic b);
    if (mclr != 0 || a == 0) begin
      d = '0; b = 1'b0;
    end else if (BYP && writeEnable && writeReg == a) begin
      d = writeData; b = issueEnable && (issueReg == a);
    end else begin
      d = mreg[a]; b = mpend[a];
    end
  endfunction

  always @(negedge clk) begin
    logic [63:0] ed;
    logic        eb;
    chk("cmp_ready", {63'd0, ready}, {63'd0, mclr == 0});
    for (int k = 0; k < 2; k++) begin
      exp_rd(readReg[k*5 +: 5], ed, eb);
      chk("cmp_data", data[k*64 +: 64], ed);
      chk("cmp_busy", {63'd0, busy[k]}, {63'd0, eb});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    readReg = {p1, p0};
    #1;
  endtask

  // Counts cycles from reset release; both instances must rise exactly at their register count.
  task automatic wait_ready();
    for (int i = 0; i <= 32; i++) begin
      if (i > 0) tick();
      chk("ready_rise", {63'd0, ready}, {63'd0, i == 32});
      chk("ready2_rise", {63'd0, ready2}, {63'd0, i >= 16});
    end
  endtask

  initial begin
    rst = 1'b1;
    readReg = '0; issueEnable = 0; issueReg = '0;
    writeEnable = 0; writeReg = '0; writeData = '0;
    readReg2 = '0; issueEnable2 = 0; issueReg2 = '0;
    writeEnable2 = 0; writeReg2 = '0; writeData2 = '0;
    tick(); tick();
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_busy", {62'd0, busy}, 64'd0);
    rst = 1'b0;
    wait_ready();

    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(31 - r));
      chk("clear_p0", data[63:0], 64'd0);
      chk("clear_p1", data[127:64], 64'd0);
    end

    // NRD=3, NREG=16 instance
    writeEnable2 = 1; writeReg2 = 4'd4; writeData2 = 64'h77;
    tick();
    writeEnable2 = 0;
    readReg2 = {4'd4, 4'd4, 4'd4};
    #1;
    chk("n3_p0", data2[63:0], 64'h77);
    chk("n3_p1", data2[127:64], 64'h77);
    chk("n3_p2", data2[191:128], 64'h77);

    writeEnable = 1; writeReg = 5'd5; writeData = 64'h0000_0000_DEAD_BEEF;
    rd(5'd5, 5'd0);
    tick();
    writeEnable = 0;
    #1;
    chk("x5_data", data[63:0], 64'h0000_0000_DEAD_BEEF);
    chk("x5_busy", {63'd0, busy[0]}, 64'd0);
    writeEnable = 1; writeReg = 5'd0; writeData = 64'h1234;
    rd(5'd0, 5'd5);
    tick();
    writeEnable = 0;
    #1;
    chk("x0_zero", data[63:0], 64'd0);

    issueEnable = 1; issueReg = 5'd7;
    tick();
    issueEnable = 0;
    rd(5'd0, 5'd7);
    chk("x7_busy_set", {63'd0, busy[1]}, 64'd1);
    writeEnable = 1; writeReg = 5'd7; writeData = 64'h55;
    tick();
    writeEnable = 0;
    #1;
    chk("x7_busy_clr", {63'd0, busy[1]}, 64'd0);
    chk("x7_data55", data[127:64], 64'h55);
    issueEnable = 1; issueReg = 5'd7;
    writeEnable = 1; writeReg = 5'd7; writeData = 64'h66;
    tick();
    issueEnable = 0; writeEnable = 0;
    #1;
    chk("x7_data66", data[127:64], 64'h66);
    chk("x7_issue_wins", {63'd0, busy[1]}, 64'd1);

    issueEnable = 1; issueReg = 5'd8;
    writeEnable = 1; writeReg = 5'd9; writeData = 64'hAB;
    tick();
    issueEnable = 0; writeEnable = 0;
    rd(5'd8, 5'd9);
    chk("x8_busy", {63'd0, busy[0]}, 64'd1);
    chk("x9_data", data[127:64], 64'hAB);
    chk("x9_busy", {63'd0, busy[1]}, 64'd0);

    writeEnable = 1; writeReg = 5'd3; writeData = 64'h11;
    tick();
    writeData = 64'h22;
    rd(5'd3, 5'd0);
    chk("byp_same", data[63:0], BYP ? 64'h22 : 64'h11);
    tick();
    writeEnable = 0;
    #1;
    chk("byp_next", data[63:0], 64'h22);
    issueEnable = 1; issueReg = 5'd3;
    writeEnable = 1; writeReg = 5'd3; writeData = 64'h33;
    #1;
    chk("byp_iss_data", data[63:0], BYP ? 64'h33 : 64'h22);
    chk("byp_iss_busy", {63'd0, busy[0]}, BYP ? 64'd1 : 64'd0);
    tick();
    issueEnable = 0; writeEnable = 0;
    #1;
    chk("x3_data33", data[63:0], 64'h33);
    chk("x3_busy", {63'd0, busy[0]}, 64'd1);

    // Reset in the middle of a clear walk
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("midclr_ready", {63'd0, ready}, 64'd0);
    writeEnable = 1; writeReg = 5'd10; writeData = 64'hCC;
    issueEnable = 1; issueReg = 5'd11;
    tick();
    writeEnable = 0; issueEnable = 0;
    rst = 1'b1;
    tick();
    chk("rst_ready", {63'd0, ready}, 64'd0);
    rst = 1'b0;
    wait_ready();
    rd(5'd9, 5'd10);
    chk("x9_cleared", data[63:0], 64'd0);
    chk("x10_dropped", data[127:64], 64'd0);
    rd(5'd8, 5'd11);
    chk("x8_pend_clr", {63'd0, busy[0]}, 64'd0);
    chk("x11_pend_clr", {63'd0, busy[1]}, 64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
